// File: rtl/melody_sequencer.sv
// Door-chime sequencer: a rising edge on the IR sensor plays a fixed 8-note
// melody as half-period/enable pairs for a square-wave tone generator, then holds off.
`timescale 1ns/1ps
module melody_sequencer #(
    parameter int TICK_DIV       = 2500000,
    parameter int GAP_TICKS      = 1,
    parameter int COOLDOWN_TICKS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir0,
    output logic [17:0] half_period,
    output logic        tone_on,
    output logic        busy,
    output logic        done
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]      GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [7:0]      COOL_LAST  = 8'(COOLDOWN_TICKS - 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP, COOLDOWN} state_t;

    state_t        state, state_d;
    logic [2:0]    idx, idx_d;
    logic [PW-1:0] presc;
    logic [7:0]    tcnt;
    logic          sync1, sync2, sync3;
    logic          trig, tick, cnt_clr;
    logic [17:0]   hp_d;
    logic          tone_d, busy_d, done_d;

    function automatic logic [17:0] rom_half(input logic [2:0] i);
        case (i)
            3'd0:    rom_half = 18'd33785;
            3'd1:    rom_half = 18'd42566;
            3'd2:    rom_half = 18'd56818;
            3'd3:    rom_half = 18'd42566;
            3'd4:    rom_half = 18'd37921;
            3'd5:    rom_half = 18'd28409;
            3'd6:    rom_half = 18'd37921;
            default: rom_half = 18'd33785;
        endcase
    endfunction

    // Last tick index of each note (note length in ticks minus one).
    function automatic logic [7:0] rom_last(input logic [2:0] i);
        case (i)
            3'd5, 3'd7: rom_last = 8'd29;
            default:    rom_last = 8'd14;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ir0;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign trig = sync2 & ~sync3;
    assign tick = (presc == PRESC_LAST);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        hp_d    = half_period;
        tone_d  = tone_on;
        busy_d  = busy;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        case (state)
            IDLE: if (trig) begin
                state_d = NOTE;
                idx_d   = 3'd0;
                hp_d    = rom_half(3'd0);
                tone_d  = 1'b1;
                busy_d  = 1'b1;
                cnt_clr = 1'b1;
            end
            NOTE: if (tick && tcnt == rom_last(idx)) begin
                cnt_clr = 1'b1;
                tone_d  = 1'b0;
                if (idx == 3'd7) begin
                    state_d = COOLDOWN;
                    hp_d    = 18'd0;
                    done_d  = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: if (tick && tcnt == GAP_LAST) begin
                cnt_clr = 1'b1;
                state_d = NOTE;
                idx_d   = idx + 3'd1;
                hp_d    = rom_half(idx + 3'd1);
                tone_d  = 1'b1;
            end
            COOLDOWN: if (tick && tcnt == COOL_LAST) begin
                cnt_clr = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they change only on transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            presc       <= '0;
            tcnt        <= 8'd0;
            half_period <= 18'd0;
            tone_on     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            half_period <= hp_d;
            tone_on     <= tone_d;
            busy        <= busy_d;
            done        <= done_d;
            if (cnt_clr || state == IDLE) begin
                presc <= '0;
                tcnt  <= 8'd0;
            end else if (tick) begin
                presc <= '0;
                tcnt  <= tcnt + 8'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus random IR activity, checked
// cycle by cycle against a timeline model built from the note table.
`timescale 1ns/1ps
module tb_melody_sequencer;
    localparam int TD   = 4;
    localparam int GT   = 1;
    localparam int CT   = 10;
    localparam int NONE = -1000000;
    localparam int HP[8] = '{33785, 42566, 56818, 42566, 37921, 28409, 37921, 33785};
    localparam int NT[8] = '{15, 15, 15, 15, 15, 30, 15, 30};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir0;
    logic [17:0] half_period;
    logic        tone_on, busy, done;

    int total, bad;
    int edge_n, start_e, pend, rise_e, done_e;
    logic prev_s, p_busy;

    melody_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .COOLDOWN_TICKS(CT)) dut (
        .clk(clk), .rst_n(rst_n), .ir0(ir0),
        .half_period(half_period), .tone_on(tone_on), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    // Expected {half_period, tone_on, busy, done} after edge n, from the melody timeline.
    function automatic logic [20:0] model_out(input int n);
        int t;
        if (start_e == NONE) return '0;
        t = n - start_e;
        if (t < 0) return '0;
        for (int i = 0; i < 8; i++) begin
            if (t < NT[i] * TD) return {18'(HP[i]), 3'b110};
            t -= NT[i] * TD;
            if (i < 7) begin
                if (t < GT * TD) return {18'(HP[i]), 3'b010};
                t -= GT * TD;
            end
        end
        if (t < CT * TD) return {18'd0, 2'b01, (t == 0)};
        return '0;
    endfunction

    function automatic logic model_busy(input int n);
        logic [20:0] v;
        v = model_out(n);
        return v[1];
    endfunction

    task automatic model_reset();
        start_e = NONE;
        pend    = NONE;
        prev_s  = 1'b0;
        p_busy  = 1'b0;
    endtask

    // A sampled rise at edge k starts a melody at edge k+2 if idle after edge k+1.
    task automatic model_edge(input logic v);
        if (pend == edge_n && !model_busy(edge_n - 1)) start_e = edge_n;
        if (v && !prev_s) pend = edge_n + 2;
        prev_s = v;
    endtask

    task automatic step(input logic v);
        ir0 = v;
        @(posedge clk);
        edge_n++;
        model_edge(v);
        #1;
        chk("outputs", {11'd0, half_period, tone_on, busy, done}, {11'd0, model_out(edge_n)});
        if (busy && !p_busy) rise_e = edge_n;
        if (done) begin
            chk("done_latency", 32'(edge_n - rise_e), 32'd628);
            done_e = edge_n;
        end
        if (!busy && p_busy) chk("busy_fall", 32'(edge_n - done_e), 32'd40);
        p_busy = busy;
    endtask

    task automatic run(input int n, input logic v);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic run_until(input int off, input logic v);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (start_e != NONE && model_busy(edge_n) && edge_n - start_e >= off) hit = 1'b1;
            else step(v);
        end
        chk("reach_offset", 32'(hit), 32'd1);
    endtask

    task automatic rst_cycle(input logic v);
        ir0 = v;
        @(posedge clk);
        #1;
        chk("reset_hold", {11'd0, half_period, tone_on, busy, done}, 32'd0);
    endtask

    initial begin
        logic cur;
        total = 0; bad = 0; edge_n = 0; rise_e = 0; done_e = 0;
        rst_n = 1'b0; ir0 = 1'b0;
        model_reset();
        #2;
        chk("reset_async", {11'd0, half_period, tone_on, busy, done}, 32'd0);
        for (int i = 0; i < 6; i++) rst_cycle(1'(i & 1));
        ir0 = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // single trigger, held high through cooldown end (no re-arm)
        run(4, 1'b0);
        run(700, 1'b1);

        // retrigger pulses during note 2 are discarded
        run(20, 1'b0);
        run_until(130, 1'b1);
        for (int p = 0; p < 3; p++) begin
            run($urandom_range(1, 3), 1'b0);
            run($urandom_range(1, 3), 1'b1);
        end
        run(700, 1'b1);

        // re-arm with a fresh edge
        run(10, 1'b0);
        run(700, 1'b1);

        // random sensor activity
        cur = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) cur = ~cur;
            step(cur);
        end
        run(700, 1'b0);

        // asynchronous reset in the middle of note 5
        run_until(320 + $urandom_range(0, 100), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_async", {11'd0, half_period, tone_on, busy, done}, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) rst_cycle(1'b0);
        @(negedge clk) rst_n = 1'b1;
        run(50, 1'b0);

        // one-cycle glitch still plays a full melody
        step(1'b1);
        run(700, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
